// File: rtl/serializer16_pkg.sv
// Shared constants, state encoding and bit-order helpers for serializer16.
package serializer16_pkg;

    localparam int SER_WIDTH = 16;
    localparam int SER_IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Index of the first bit put on the wire for the chosen bit order.
    function automatic logic [SER_IDX_W-1:0] first_idx(input bit msb_first);
        return msb_first ? SER_IDX_W'(SER_WIDTH - 1) : '0;
    endfunction

    // Index of the final bit of a word for the chosen bit order.
    function automatic logic [SER_IDX_W-1:0] last_idx(input bit msb_first);
        return msb_first ? '0 : SER_IDX_W'(SER_WIDTH - 1);
    endfunction

endpackage

// File: rtl/serializer16_mux16x4.sv
// 16:1 single-bit multiplexer; purely combinational, zero latency, no flow control.
module mux16x4 (
    input  logic [15:0] in,
    input  logic [3:0]  sel,
    output logic        out
);

    assign out = in[sel];

endmodule

// File: rtl/serializer16.sv
// 16-bit word to bit-serial converter with valid/ready on both sides; first bit one cycle after accept.
// Stalls hold bit and index; a new word is accepted on the last-bit transfer so words stream without bubbles.
module serializer16
    import serializer16_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [SER_WIDTH-1:0] load_data,
    output logic                 ser_out,
    output logic                 ser_valid,
    input  logic                 ser_ready,
    output logic                 ser_last,
    output logic                 busy
);

    localparam logic [SER_IDX_W-1:0] FIRST_IDX = first_idx(MSB_FIRST);
    localparam logic [SER_IDX_W-1:0] LAST_IDX  = last_idx(MSB_FIRST);

    state_e                 state_q, state_d;
    logic [SER_IDX_W-1:0]   idx_q, idx_d;
    logic [SER_WIDTH-1:0]   hold_q, hold_d;

    logic                   mux_bit;
    logic                   in_shift;
    logic                   accept;
    logic                   xfer;

    mux16x4 u_mux (
        .in  (hold_q),
        .sel (idx_q),
        .out (mux_bit)
    );

    assign in_shift   = (state_q == SHIFT);
    assign ser_valid  = in_shift;
    assign ser_last   = in_shift && (idx_q == LAST_IDX);
    assign ser_out    = in_shift && mux_bit;
    assign busy       = in_shift;
    assign load_ready = !in_shift || (ser_last && ser_ready);
    assign accept     = load_valid && load_ready;
    assign xfer       = ser_valid && ser_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        if (accept) begin
            // Covers both a load from IDLE and the back-to-back reload on the last bit.
            state_d = SHIFT;
            idx_d   = FIRST_IDX;
            hold_d  = load_data;
        end else if (xfer) begin
            if (ser_last) begin
                state_d = IDLE;
            end else if (MSB_FIRST) begin
                idx_d = idx_q - 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_serializer16.sv
// Directed bench for serializer16: both bit orders, stalls, back-to-back, ignored loads and mid-word reset.
module tb_serializer16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] load_data;
    logic        ser_ready;

    logic lv0, lr0, so0, sv0, sl0, b0;
    logic lv1, lr1, so1, sv1, sl1, b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serializer16 #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (lv0),
        .load_ready (lr0),
        .load_data  (load_data),
        .ser_out    (so0),
        .ser_valid  (sv0),
        .ser_ready  (ser_ready),
        .ser_last   (sl0),
        .busy       (b0)
    );

    serializer16 #(.MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (lv1),
        .load_ready (lr1),
        .load_data  (load_data),
        .ser_out    (so1),
        .ser_valid  (sv1),
        .ser_ready  (ser_ready),
        .ser_last   (sl1),
        .busy       (b1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load0(input logic [15:0] w);
        lv0       = 1'b1;
        load_data = w;
        check("load_rdy", 32'(lr0), 32'd1);
        tick;
        lv0       = 1'b0;
        load_data = 16'h0000;
    endtask

    // seq[i] is the i-th bit expected on the wire.
    task automatic stream0(input string tag, input logic [15:0] seq,
                           input int stall_at, input int stall_len, input int pulse_at);
        int i       = 0;
        int cyc     = 0;
        int stalled = 0;
        int xfers   = 0;
        while (i < 16 && cyc < 64) begin
            check({tag, "_vld"},  32'(sv0), 32'd1);
            check({tag, "_bit"},  32'(so0), 32'(seq[i]));
            check({tag, "_last"}, 32'(sl0), 32'(i == 15));
            ser_ready = !(i == stall_at && stalled < stall_len);
            lv0       = (i == pulse_at);
            if (lv0) begin
                load_data = 16'h1234;
                check({tag, "_ign_rdy"}, 32'(lr0), 32'd0);
            end
            if (ser_ready && sv0) xfers++;
            tick;
            lv0 = 1'b0;
            if (ser_ready) i++;
            else stalled++;
            cyc++;
        end
        ser_ready = 1'b1;
        check({tag, "_xfers"}, 32'(xfers), 32'd16);
        check({tag, "_end_busy"}, 32'(b0),  32'd0);
        check({tag, "_end_vld"},  32'(sv0), 32'd0);
        check({tag, "_end_rdy"},  32'(lr0), 32'd1);
    endtask

    initial begin
        logic [15:0] w;
        int          run;

        // Reset with load_valid asserted: nothing may be captured.
        rst_n     = 1'b0;
        lv0       = 1'b1;
        lv1       = 1'b1;
        load_data = 16'hDEAD;
        ser_ready = 1'b1;
        repeat (3) tick;
        check("rst_rdy",  32'(lr0), 32'd1);
        check("rst_vld",  32'(sv0), 32'd0);
        check("rst_out",  32'(so0), 32'd0);
        check("rst_last", 32'(sl0), 32'd0);
        check("rst_busy", 32'(b0),  32'd0);
        check("rst_vld1", 32'(sv1), 32'd0);
        lv0   = 1'b0;
        lv1   = 1'b0;
        rst_n = 1'b1;
        tick;
        check("post_rst_vld",  32'(sv0), 32'd0);
        check("post_rst_busy", 32'(b0),  32'd0);
        check("post_rst_vld1", 32'(sv1), 32'd0);

        // LSB-first A5C3: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1
        load0(16'hA5C3);
        stream0("lsb_a5c3", 16'hA5C3, -1, 0, -1);

        // FF00 with a 3-cycle stall after bit 2: 8x0 then 8x1.
        load0(16'hFF00);
        stream0("stall_ff00", 16'hFF00, 3, 3, -1);

        // 0FF0 in flight while 1234 is offered: must be ignored.
        load0(16'h0FF0);
        stream0("ign_1234", 16'h0FF0, -1, 0, 6);

        // Back-to-back A5C3 then 5A3C with load_valid held high.
        lv0       = 1'b1;
        load_data = 16'hA5C3;
        tick;
        load_data = 16'h5A3C;
        run = 0;
        for (int i = 0; i < 32; i++) begin
            w = (i < 16) ? 16'hA5C3 : 16'h5A3C;
            check("b2b_vld",  32'(sv0), 32'd1);
            check("b2b_bit",  32'(so0), 32'(w[i % 16]));
            check("b2b_last", 32'(sl0), 32'((i % 16) == 15));
            if (i == 0)  check("b2b_rdy_busy", 32'(lr0), 32'd0);
            if (i == 15) check("b2b_rdy_last", 32'(lr0), 32'd1);
            if (sv0) run++;
            tick;
            if (i == 15) lv0 = 1'b0;
        end
        check("b2b_run",      32'(run), 32'd32);
        check("b2b_end_vld",  32'(sv0), 32'd0);
        check("b2b_end_rdy",  32'(lr0), 32'd1);

        // MSB-first 8001: 1, fourteen 0s, 1.
        lv1       = 1'b1;
        load_data = 16'h8001;
        check("msb_load_rdy", 32'(lr1), 32'd1);
        tick;
        lv1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("msb_vld",  32'(sv1), 32'd1);
            check("msb_bit",  32'(so1), 32'(i == 0 || i == 15));
            check("msb_last", 32'(sl1), 32'(i == 15));
            tick;
        end
        check("msb_end_busy", 32'(b1),  32'd0);
        check("msb_end_rdy",  32'(lr1), 32'd1);

        // Reset after 5 bits of FFFF, then a fresh 0001 word.
        load0(16'hFFFF);
        repeat (5) tick;
        check("mid_busy", 32'(b0),  32'd1);
        check("mid_bit",  32'(so0), 32'd1);
        rst_n = 1'b0;
        tick;
        check("mid_rst_vld",  32'(sv0), 32'd0);
        check("mid_rst_busy", 32'(b0),  32'd0);
        check("mid_rst_rdy",  32'(lr0), 32'd1);
        check("mid_rst_out",  32'(so0), 32'd0);
        rst_n = 1'b1;
        tick;
        check("mid_post_vld", 32'(sv0), 32'd0);
        load0(16'h0001);
        stream0("reload_0001", 16'h0001, -1, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
